// File: rtl/kbd_serial_receiver.sv
// Keyboard serial receiver: 8N1 UART receive path feeding a small byte FIFO,
// drained through an IRQ / IACK / IEND interrupt handshake.
// Optional feature macro: KBD_OVERFLOW_STATUS_EN adds a sticky OUT_OVERFLOW flag
// that records bytes dropped because the FIFO was full.
module kbd_serial_receiver #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned FIFO_ADDR_BITS = 3
) (
  input  logic       CLK,
  input  logic       IN_PB_RESET,
  input  logic       IN_SERIAL_RX,
  input  logic       IN_IACK,
  input  logic       IN_IEND,
`ifdef KBD_OVERFLOW_STATUS_EN
  output logic       OUT_OVERFLOW,
`endif
  output logic [7:0] OUT_BUFFER,
  output logic       OUT_IRQ
);

  localparam int unsigned Depth = 1 << FIFO_ADDR_BITS;
  localparam int unsigned PtrW  = FIFO_ADDR_BITS + 1;

  localparam logic [15:0] HalfBitM1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FullBitM1 = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  localparam logic IIdle    = 1'b0;
  localparam logic IService = 1'b1;

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall;

  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_push;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            fifo_empty, fifo_full;
  logic            pop, push_ok;

  logic       irq_state_q, irq_state_d;
  logic [7:0] buffer_q, buffer_d;
  logic       iend_ok;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= IN_SERIAL_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // Receive FSM: mid-bit sampling driven by a down-counter.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (rx_fall) begin
          rx_state_d = StStart;
          cnt_d      = HalfBitM1;
        end
      end
      StStart: begin
        if (cnt_q == 16'd0) begin
          if (!rx_sync_q) begin
            rx_state_d = StData;
            cnt_d      = FullBitM1;
            idx_d      = 3'd0;
          end else begin
            // Start bit vanished before mid-bit: treat as a glitch.
            rx_state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_q == 16'd0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FullBitM1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            rx_state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == 16'd0) begin
          // A low stop bit is a framing error; the byte is discarded.
          rx_push    = rx_sync_q;
          rx_state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // Receive FSM state, bit timer, bit index and shift register.
  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      rx_state_q <= StIdle;
      cnt_q      <= 16'd0;
      idx_q      <= 3'd0;
      shift_q    <= 8'd0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                      (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);

  assign OUT_IRQ = (irq_state_q == IIdle) && !fifo_empty;
  assign pop     = IN_IACK && OUT_IRQ;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = rx_push && (!fifo_full || pop);
  // IACK takes precedence when both strobes arrive together.
  assign iend_ok = IN_IEND && !IN_IACK && (irq_state_q == IService);

  // FIFO pointers, interrupt state and output buffer next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    irq_state_d = irq_state_q;
    buffer_d    = buffer_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PtrW'(1);
      buffer_d    = mem_q[rd_ptr_q[FIFO_ADDR_BITS-1:0]];
      irq_state_d = IService;
    end else if (iend_ok) begin
      irq_state_d = IIdle;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[FIFO_ADDR_BITS-1:0]] <= shift_q;
    end
  end

  // FIFO pointers, interrupt state and output buffer registers.
  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      irq_state_q <= IIdle;
      buffer_q    <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      irq_state_q <= irq_state_d;
      buffer_q    <= buffer_d;
    end
  end

  assign OUT_BUFFER = buffer_q;

`ifdef KBD_OVERFLOW_STATUS_EN
  logic ovf_q;
  logic drop;

  assign drop = rx_push && fifo_full && !pop;

  // Sticky overflow flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (iend_ok) begin
      ovf_q <= 1'b0;
    end
  end

  assign OUT_OVERFLOW = ovf_q;
`endif

endmodule

// File: doc/kbd_serial_receiver.md
KBD_SERIAL_RECEIVER -- requirements
Module: kbd_serial_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, gives CLK cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 Parameter FIFO_ADDR_BITS, default 3, sets receive FIFO depth to 2**FIFO_ADDR_BITS bytes.
REQ-003 CLK  input  1  single system clock; all state on rising edge.
REQ-004 IN_PB_RESET  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 IN_SERIAL_RX  input  1  asynchronous UART line, 8N1, idle high.
REQ-006 OUT_BUFFER  output  8  last byte popped by an interrupt acknowledge.
REQ-007 OUT_IRQ  output  1  interrupt request, byte pending.
REQ-008 IN_IACK  input  1  interrupt acknowledge, one-cycle pulse.
REQ-009 IN_IEND  input  1  interrupt end, one-cycle pulse.

Function
REQ-010 IN_SERIAL_RX SHALL pass through a 2-flop synchronizer; all receive logic uses the synchronized signal (2-cycle input latency).
REQ-011 Receive FSM states: IDLE, START, DATA, STOP.
REQ-012 IDLE->START on a high-to-low transition of the synchronized line; bit counter loaded with CLKS_PER_BIT/2-1.
REQ-013 START: at half-bit, line low -> DATA; line high -> IDLE (glitch rejected, nothing pushed).
REQ-014 DATA: 8 samples, each CLKS_PER_BIT cycles apart, LSB first, shifted into an 8-bit register; after 8th sample -> STOP.
REQ-015 STOP: sample after CLKS_PER_BIT cycles; high -> push byte to FIFO; low (framing error) -> discard byte; both -> IDLE.
REQ-016 FIFO: circular buffer, read/write pointers FIFO_ADDR_BITS+1 wide, wrap modulo depth; empty when pointers equal, full when only the MSBs differ.
REQ-017 Push when full SHALL drop the byte and leave FIFO contents unchanged, except when a pop occurs in the same cycle, in which case the push is accepted.
REQ-018 Interrupt FSM states: I_IDLE, I_SERVICE.
REQ-019 OUT_IRQ SHALL be 1 in I_IDLE when the FIFO is non-empty, else 0; OUT_IRQ SHALL be 0 in I_SERVICE.
REQ-020 IN_IACK while OUT_IRQ=1: pop FIFO head into OUT_BUFFER at that edge (valid the following cycle); go to I_SERVICE.
REQ-021 IN_IACK while OUT_IRQ=0 SHALL be ignored; OUT_BUFFER holds.
REQ-022 IN_IEND in I_SERVICE -> I_IDLE; OUT_IRQ re-asserts the next cycle if the FIFO is non-empty. IN_IEND in I_IDLE SHALL be ignored.
REQ-023 IN_IACK and IN_IEND together SHALL be treated as IN_IACK only.
REQ-024 OUT_BUFFER SHALL change only on an accepted IN_IACK.

Reset
REQ-025 While IN_PB_RESET=0: OUT_BUFFER=8'h00, OUT_IRQ=0, FIFO empty, both FSMs in their idle states, synchronizer flops=1, shift register and counters=0.
REQ-026 Reset mid-frame SHALL abandon the frame; after release, a start bit is detected only on a fresh high-to-low transition.
REQ-027 Reset during I_SERVICE SHALL return to I_IDLE with FIFO contents discarded.

Configuration
REQ-028 Macro KBD_OVERFLOW_STATUS_EN defined: adds output OUT_OVERFLOW (1 bit), set sticky on any dropped push (REQ-017), cleared on accepted IN_IEND or reset; reset value 0.
REQ-029 KBD_OVERFLOW_STATUS_EN undefined: OUT_OVERFLOW port and flag absent; drops are silent; all other behaviour identical.

Verification (CLKS_PER_BIT=16, FIFO_ADDR_BITS=3)
REQ-030 Send 8'h31 -> OUT_IRQ rises within 2 cycles after the stop-bit sample; IN_IACK -> OUT_BUFFER=8'h31 next cycle, OUT_IRQ=0; IN_IEND -> OUT_IRQ stays 0.
REQ-031 Send 8'h32, 8'h33, 8'h34 back-to-back, then 3 IACK/IEND rounds -> OUT_BUFFER 8'h32, 8'h33, 8'h34 in order; OUT_IRQ re-asserts one cycle after each of the first two IEND.
REQ-032 Send 10 bytes 8'h00..8'h09 with no service -> 8 pops return 8'h00..8'h07, OUT_IRQ then 0; with KBD_OVERFLOW_STATUS_EN, OUT_OVERFLOW=1 until the first IEND.
REQ-033 Low pulse of 4 cycles on IN_SERIAL_RX -> nothing pushed, OUT_IRQ stays 0; byte 8'hA5 with stop bit driven low -> discarded, OUT_IRQ stays 0.
REQ-034 IN_IACK with OUT_IRQ=0 -> OUT_BUFFER unchanged; IN_PB_RESET pulsed low during data bit 4 of 8'h55 -> all outputs 0, following clean 8'h66 received correctly.
